// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side initiator for the binary ALU.
// Takes one tagged request at a time, drives the ALU enable/operation/operand
// interface until done (or a timeout), and returns the result with error flags
// rsp_err = {illegal opcode, divide-by-zero, timeout}.
// Optional build macro ALU_SEQ_PERF_EN adds perf_ops / perf_busy / perf_err counters.
module alu_op_sequencer #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [2:0]       rsp_err,
    output logic             alu_enable,
    output logic [3:0]       alu_operation,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_done,
`ifdef ALU_SEQ_PERF_EN
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_busy,
    output logic [15:0]      perf_err,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MAX = 4'd8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               alu_enable_reg, alu_enable_next;
    logic [3:0]         alu_operation_reg, alu_operation_next;
    logic [31:0]        alu_operand_a_reg, alu_operand_a_next;
    logic [31:0]        alu_operand_b_reg, alu_operand_b_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [31:0]        rsp_result_reg, rsp_result_next;
    logic [TAG_W-1:0]   rsp_tag_reg, rsp_tag_next;
    logic [2:0]         rsp_err_reg, rsp_err_next;
    logic               busy_reg, busy_next;
    logic               cmd_accept;

    // A done still high from the previous op must not look like completion of a new one
    assign cmd_ready  = (state_reg == IDLE) && !alu_done;
    assign cmd_accept = cmd_valid && cmd_ready;

    assign alu_enable    = alu_enable_reg;
    assign alu_operation = alu_operation_reg;
    assign alu_operand_a = alu_operand_a_reg;
    assign alu_operand_b = alu_operand_b_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_tag       = rsp_tag_reg;
    assign rsp_err       = rsp_err_reg;
    assign busy          = busy_reg;

    // Next-state and next-output logic; every register holds unless a transition touches it
    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        alu_enable_next    = alu_enable_reg;
        alu_operation_next = alu_operation_reg;
        alu_operand_a_next = alu_operand_a_reg;
        alu_operand_b_next = alu_operand_b_reg;
        rsp_valid_next     = rsp_valid_reg;
        rsp_result_next    = rsp_result_reg;
        rsp_tag_next       = rsp_tag_reg;
        rsp_err_next       = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    alu_operation_next = cmd_op;
                    alu_operand_a_next = cmd_a;
                    alu_operand_b_next = cmd_b;
                    rsp_tag_next       = cmd_tag;
                    cnt_next           = '0;
                    if (cmd_op <= OP_MAX) begin
                        alu_enable_next = 1'b1;
                        state_next      = EXEC;
                    end else begin
                        // Illegal opcode: answer immediately without touching the ALU
                        rsp_result_next = '0;
                        rsp_err_next    = 3'b100;
                        rsp_valid_next  = 1'b1;
                        state_next      = RESP;
                    end
                end
            end
            EXEC: begin
                if (alu_done) begin
                    rsp_result_next = alu_result;
                    rsp_err_next    = {1'b0, (alu_operation_reg == OP_DIV) && (alu_operand_b_reg == 32'd0), 1'b0};
                    rsp_valid_next  = 1'b1;
                    alu_enable_next = 1'b0;
                    state_next      = RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_next = '0;
                    rsp_err_next    = 3'b001;
                    rsp_valid_next  = 1'b1;
                    alu_enable_next = 1'b0;
                    state_next      = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            alu_enable_reg    <= 1'b0;
            alu_operation_reg <= '0;
            alu_operand_a_reg <= '0;
            alu_operand_b_reg <= '0;
            rsp_valid_reg     <= 1'b0;
            rsp_result_reg    <= '0;
            rsp_tag_reg       <= '0;
            rsp_err_reg       <= '0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            alu_enable_reg    <= alu_enable_next;
            alu_operation_reg <= alu_operation_next;
            alu_operand_a_reg <= alu_operand_a_next;
            alu_operand_b_reg <= alu_operand_b_next;
            rsp_valid_reg     <= rsp_valid_next;
            rsp_result_reg    <= rsp_result_next;
            rsp_tag_reg       <= rsp_tag_next;
            rsp_err_reg       <= rsp_err_next;
            busy_reg          <= busy_next;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_ops_reg, perf_busy_reg;
    logic [15:0] perf_err_reg;

    assign perf_ops  = perf_ops_reg;
    assign perf_busy = perf_busy_reg;
    assign perf_err  = perf_err_reg;

    // Activity counters: ops and busy wrap, error count saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops_reg  <= '0;
            perf_busy_reg <= '0;
            perf_err_reg  <= '0;
        end else begin
            if (busy_reg)
                perf_busy_reg <= perf_busy_reg + 32'd1;
            if (rsp_valid_reg && rsp_ready) begin
                perf_ops_reg <= perf_ops_reg + 32'd1;
                if ((rsp_err_reg != 3'b000) && (perf_err_reg != 16'hFFFF))
                    perf_err_reg <= perf_err_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU, directed commands with
// hand-computed responses queued to a scoreboard, and a monitor that checks
// each response handshake (result, tag, error flags, latency).
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [2:0]  rsp_err;
    logic        alu_enable;
    logic [3:0]  alu_operation;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [31:0] alu_result;
    logic        alu_done;
    logic        busy;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_ops, perf_busy;
    logic [15:0] perf_err;
`endif

    alu_op_sequencer #(.TAG_W(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .alu_enable(alu_enable), .alu_operation(alu_operation),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_result(alu_result), .alu_done(alu_done),
`ifdef ALU_SEQ_PERF_EN
        .perf_ops(perf_ops), .perf_busy(perf_busy), .perf_err(perf_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int busy_cyc = 0;
    bit force_no_done = 1'b0;
    int done_linger = 0;
    int alu_cnt = 0;
    int linger = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (alu_enable) en_cnt <= en_cnt + 1;
    always @(posedge clk or posedge reset)
        if (reset) busy_cyc <= 0;
        else if (busy) busy_cyc <= busy_cyc + 1;

    function automatic int op_lat(input logic [3:0] op);
        case (op)
            4'd2:    return 2;
            4'd3:    return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Behavioural ALU: done rises after a per-op number of enabled cycles,
    // optionally lingers after enable drops to emulate a slow-clearing done
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done <= 1'b0; alu_result <= '0; alu_cnt <= 0; linger <= 0;
        end else if (alu_enable) begin
            linger <= 0;
            if (!alu_done && !force_no_done) begin
                if (alu_cnt + 1 >= op_lat(alu_operation)) begin
                    alu_done   <= 1'b1;
                    alu_result <= alu_calc(alu_operation, alu_operand_a, alu_operand_b);
                    alu_cnt    <= 0;
                end else begin
                    alu_cnt <= alu_cnt + 1;
                end
            end
        end else begin
            alu_cnt <= 0;
            if (alu_done && linger < done_linger) linger <= linger + 1;
            else begin alu_done <= 1'b0; linger <= 0; end
        end
    end

    // Monitor: compare every response handshake against the scoreboard head
    initial begin
        bit prev_valid = 1'b0;
        int rise_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready && !reset) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_tag), 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_result", 64'(rsp_result), 64'(e.res));
                    check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.lat >= 0)
                        check("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit push, input logic [31:0] er,
                         input logic [2:0] ee, input int lat);
        int n = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (push) begin
            e.res = er; e.tag = tag; e.err = ee; e.lat = lat; e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || rsp_valid || sb_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int en_base;
        int n;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rsp_valid, busy, alu_enable, rsp_err, rsp_tag, rsp_result}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);

        // ADD 5+7, enable must be high for exactly two cycles
        en_base = en_cnt;
        issue(4'd0, 32'd5, 32'd7, 4'd3, 1, 32'd12, 3'b000, 2);
        wait_idle();
        check("add_enable_cycles", 64'(en_cnt - en_base), 64'd2);

        // MUL then DIV with a done that lingers one cycle after enable drops
        done_linger = 1;
        issue(4'd2, 32'd6, 32'd7, 4'd5, 1, 32'd42, 3'b000, 3);
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin @(negedge clk); n++; end
        check("stale_done_blocks", 64'({cmd_ready, alu_done}), 64'b01);
        @(negedge clk);
        check("ready_after_done_clr", 64'(cmd_ready), 64'd1);
        done_linger = 0;
        issue(4'd3, 32'd100, 32'd7, 4'd6, 1, 32'd14, 3'b000, 5);
        wait_idle();

        // Divide by zero
        issue(4'd3, 32'd9, 32'd0, 4'd7, 1, 32'hFFFF_FFFF, 3'b010, 5);
        wait_idle();

        // Timeout: ALU never answers
        force_no_done = 1'b1;
        en_base = en_cnt;
        issue(4'd0, 32'd1, 32'd2, 4'd8, 1, 32'd0, 3'b001, 16);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        check("timeout_enable_drop", 64'(alu_enable), 64'd0);
        check("timeout_enable_cycles", 64'(en_cnt - en_base), 64'd16);
        wait_idle();
        force_no_done = 1'b0;

        // Illegal opcode with the consumer stalled for five cycles
        rsp_ready = 1'b0;
        en_base = en_cnt;
        issue(4'd12, 32'd3, 32'd4, 4'd9, 1, 32'd0, 3'b100, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({rsp_valid, cmd_ready, alu_enable, rsp_err, rsp_tag, rsp_result}),
                  64'({1'b1, 1'b0, 1'b0, 3'b100, 4'd9, 32'd0}));
        end
        check("illegal_no_enable", 64'(en_cnt - en_base), 64'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle();

        // XOR
        issue(4'd6, 32'h0000_F0F0, 32'h0000_FF00, 4'd10, 1, 32'h0000_0FF0, 3'b000, 2);
        wait_idle();

        // Reset in the middle of a DIV
        issue(4'd3, 32'd50, 32'd5, 4'd11, 0, 32'd0, 3'b000, 0);
        @(negedge clk);
        check("mid_exec_enable", 64'(alu_enable), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", 64'({alu_enable, alu_operation, rsp_valid, rsp_err, rsp_tag, busy}), 64'd0);
        check("mid_reset_operands", {alu_operand_a, alu_operand_b}, 64'd0);
        check("mid_reset_result", 64'(rsp_result), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 64'(cmd_ready), 64'd1);

        // ADD, DIV by zero, illegal: also the activity-counter sequence
        issue(4'd0, 32'd20, 32'd22, 4'd1, 1, 32'd42, 3'b000, 2);
        wait_idle();
        issue(4'd3, 32'd1, 32'd0, 4'd2, 1, 32'hFFFF_FFFF, 3'b010, 5);
        wait_idle();
        issue(4'd15, 32'd0, 32'd0, 4'd4, 1, 32'd0, 3'b100, -1);
        wait_idle();
`ifdef ALU_SEQ_PERF_EN
        check("perf_ops", 64'(perf_ops), 64'd3);
        check("perf_err", 64'(perf_err), 64'd2);
        check("perf_busy", 64'(perf_busy), 64'(busy_cyc));
`endif
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
